// File: rtl/mips_cpu_muldiv.sv
// Iterative multiply/divide unit that owns the Hi/Lo registers.
// One shift-add or restoring-divide step per cycle; WIDTH steps per operation.
module mips_cpu_muldiv #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MADDU = 3'd7;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic               madd_q, madd_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;

  logic               sgn;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum, rem_sh, diff;
  logic [2*WIDTH-1:0] mul_next, div_next, prod, macc;
  logic [WIDTH-1:0]   quo, rem;
  logic               last;

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
  assign last = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    sgn   = (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD);
    abs_a = (sgn && a[WIDTH-1]) ? -a : a;
    abs_b = (sgn && b[WIDTH-1]) ? -b : b;

    // Multiply: acc holds {partial product, remaining multiplier bits}.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: acc holds {partial remainder, dividend bits / quotient bits}.
    rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    diff     = rem_sh - {1'b0, opb_q};
    div_next = {(diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0]),
                acc_q[WIDTH-2:0], ~diff[WIDTH]};

    prod = neg_q ? -mul_next : mul_next;
    macc = {hi_q, lo_q} + prod;
    quo  = neg_q ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
    rem  = rneg_q ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    madd_d  = madd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          cnt_d = '0;
          case (op)
            OP_MTHI: begin
              hi_d   = a;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = a;
              done_d = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
              state_d = DIV;
              acc_d   = {{WIDTH{1'b0}}, abs_a};
              opb_d   = abs_b;
              // Divide by zero keeps the all-ones quotient un-negated.
              neg_d   = sgn && (a[WIDTH-1] ^ b[WIDTH-1]) && (b != '0);
              rneg_d  = sgn && a[WIDTH-1];
              madd_d  = 1'b0;
            end
            default: begin
              state_d = MUL;
              acc_d   = {{WIDTH{1'b0}}, abs_b};
              opb_d   = abs_a;
              neg_d   = sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
              rneg_d  = 1'b0;
              madd_d  = (op == OP_MADD) || (op == OP_MADDU);
            end
          endcase
        end
      end
      MUL, DIV: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          acc_d = (state_q == MUL) ? mul_next : div_next;
          if (last) begin
            state_d = IDLE;
            done_d  = 1'b1;
            if (state_q == DIV) begin
              hi_d = rem;
              lo_d = quo;
            end else if (madd_q) begin
              {hi_d, lo_d} = macc;
            end else begin
              {hi_d, lo_d} = prod;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      madd_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      madd_q  <= madd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

endmodule
